// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a DEPTH-bit word over valid/ready
// and shifts it out one bit per enabled clock, MSB- or LSB-first.
module piso_shift_transmitter #(
  parameter int DEPTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DEPTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [DEPTH-1:0] shiftReg_q, shiftReg_d;
  logic             out_q, out_d;
  logic             outValid_q, outValid_d;
  logic             busy_q, busy_d;
  logic             lastBit;
  logic             accept;

  // The last-bit cycle also offers ready so consecutive frames run without a gap.
  assign lastBit  = (state_q == SHIFT) && (bitCnt_q == CW'(DEPTH - 1));
  assign in_ready = enable & ((state_q == IDLE) | lastBit);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      out_q      <= 1'b0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    out_d      = out_q;
    outValid_d = outValid_q;
    busy_d     = busy_q;
    if (accept) begin
      state_d    = SHIFT;
      bitCnt_d   = '0;
      shiftReg_d = in_data;
      out_d      = MSB_FIRST ? in_data[DEPTH-1] : in_data[0];
      outValid_d = 1'b1;
      busy_d     = 1'b1;
    end else if (enable && (state_q == SHIFT)) begin
      if (!lastBit) begin
        // The register keeps the bit currently on out at its output end.
        shiftReg_d = MSB_FIRST ? {shiftReg_q[DEPTH-2:0], 1'b0}
                               : {1'b0, shiftReg_q[DEPTH-1:1]};
        out_d      = MSB_FIRST ? shiftReg_q[DEPTH-2] : shiftReg_q[1];
        bitCnt_d   = bitCnt_q + CW'(1);
      end else begin
        state_d    = IDLE;
        out_d      = 1'b0;
        outValid_d = 1'b0;
        busy_d     = 1'b0;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;

endmodule
